// File: rtl/fifo_rd_sched_pkg.sv
// Shared types and helpers for the read-side FIFO scheduler.
package fifo_rd_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_sched_rr_pick.sv
// Combinational round-robin picker: first request strictly after 'last'.
module fifo_rd_sched_rr_pick
    import fifo_rd_sched_pkg::*;
#(
    parameter int N = 4,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_rd_sched.sv
// Drains NUM_CH FWFT async-FIFO read ports into one tagged valid/ready
// stream using round-robin grants limited to BURST_MAX pops each.
module fifo_rd_sched
    import fifo_rd_sched_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4,
    localparam int CW = clog2(NUM_CH),
    localparam int BW = clog2(BURST_MAX + 1)
) (
    input  logic                         rclk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [NUM_CH-1:0]            empty_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] rdata_i,
    output logic [NUM_CH-1:0]            rinc_o,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [CW-1:0]                m_chan,
    output logic [NUM_CH-1:0]            grant_o,
    output logic                         busy
);

    state_e                state_q, state_d;
    logic [NUM_CH-1:0]     grant_q, grant_d;
    logic [CW-1:0]         gidx_q, gidx_d;
    logic [BW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         last_q, last_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [CW-1:0]         m_chan_q, m_chan_d;

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] pick_gnt;
    logic [CW-1:0]     pick_idx;
    logic              pick_any;
    logic              slot_free;
    logic              g_elig;
    logic              pop;
    logic              last_pop;

    assign elig      = ch_en & ~empty_i;
    assign slot_free = ~m_valid_q | m_ready;
    assign g_elig    = elig[gidx_q];
    assign pop       = (state_q == BURST) & g_elig & slot_free;
    assign last_pop  = (cnt_q == BW'(BURST_MAX - 1));

    assign rinc_o  = pop ? grant_q : '0;
    assign grant_o = grant_q;
    assign busy    = (state_q == BURST);
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_chan  = m_chan_q;

    fifo_rd_sched_rr_pick #(
        .N(NUM_CH)
    ) u_rr_pick (
        .req    (elig),
        .last   (last_q),
        .gnt    (pick_gnt),
        .gnt_idx(pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_chan_d  = m_chan_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BURST;
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                // Burst ends on its final pop, or when the channel runs dry.
                if (pop ? last_pop : !g_elig) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end
            end
            default: ;
        endcase
        if (pop) begin
            cnt_d     = cnt_q + BW'(1);
            m_valid_d = 1'b1;
            m_data_d  = rdata_i[gidx_q*DATA_WIDTH +: DATA_WIDTH];
            m_chan_d  = gidx_q;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            cnt_q     <= '0;
            last_q    <= CW'(NUM_CH - 1);
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_chan_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_chan_q  <= m_chan_d;
        end
    end

endmodule

// File: doc/fifo_rd_sched.md
Name: fifo_rd_sched

Overview:
- Read-side scheduler in the rclk domain that drains NUM_CH async-FIFO read ports into one valid/ready output stream.
- Each channel is a read-pointer/empty block plus its memory, presenting a registered empty and first-word-fall-through data.
- The block arbitrates round-robin with a per-grant burst limit and generates each FIFO's rinc.
- It never pops an empty FIFO and tags every output word with its source channel.

Parameters:
- NUM_CH, 4, number of FIFO read ports served (>=2)
- DATA_WIDTH, 8, FIFO word width
- BURST_MAX, 4, maximum consecutive pops per grant (>=1)

Ports:
- rclk  input  1  read-domain clock
- rst_n  input  1  reset, asynchronous, active-low
- ch_en  input  NUM_CH  per-channel enable mask, static or quasi-static
- empty_i  input  NUM_CH  registered empty flag from each channel's read-pointer block
- rdata_i  input  NUM_CH*DATA_WIDTH  head word per channel, valid whenever its empty_i=0; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- rinc_o  output  NUM_CH  one-hot-or-zero pop strobe to each FIFO
- m_valid  output  1  output word valid
- m_ready  input  1  downstream accept
- m_data  output  DATA_WIDTH  output word
- m_chan  output  clog2(NUM_CH)  source channel of m_data
- grant_o  output  NUM_CH  one-hot current grant, zero in IDLE
- busy  output  1  high in BURST state

Behaviour:
- Reset values:
  - state=IDLE, m_valid=0, m_data=0, m_chan=0.
  - grant=0, burst_cnt=0, last_grant=NUM_CH-1, so channel 0 has first priority.
  - rinc_o=0 and busy=0 follow combinationally.
- Eligibility: elig[c] = ch_en[c] & ~empty_i[c].
- Output slot: slot_free = ~m_valid | m_ready.
- IDLE:
  - If any elig, pick the first eligible channel strictly after last_grant (modulo NUM_CH).
  - Register it in grant, clear burst_cnt, go to BURST.
  - No pop happens in IDLE, giving a one-cycle arbitration bubble per grant.
- BURST, channel g:
  - pop = elig[g] & slot_free, and rinc_o[g] = pop, combinational.
  - On pop: m_data <= rdata_i[g], m_chan <= g, m_valid <= 1, burst_cnt++.
  - Exit to IDLE with last_grant <= g on the first of the following:
    - pop with burst_cnt+1 == BURST_MAX;
    - elig[g]=0 (FIFO empty or channel disabled), with no pop that cycle.
  - Backpressure (slot_free=0): hold state and burst_cnt, no pop, grant kept.
- Output register:
  - m_valid clears on m_ready & ~pop.
  - m_ready & pop in the same cycle: the word is replaced and m_valid stays 1.
  - m_data and m_chan are stable while m_valid & ~m_ready.
- Throughput and latency:
  - rinc_o high in cycle N gives m_valid/m_data at N+1.
  - Back-to-back pops on a channel are legal, since the FIFO's empty is registered with the pop folded in.
  - Sustained rate is BURST_MAX words per BURST_MAX+1 cycles.
- Invariants:
  - rinc_o is zero or one-hot.
  - rinc_o[c]=1 implies empty_i[c]=0 and ch_en[c]=1.
  - No word is dropped or duplicated.
- Single channel eligible: it is re-granted after each burst, with one bubble.
- Channel disabled mid-burst: no further pop from that cycle; return to IDLE next edge.
- Reset mid-operation: all state clears immediately. A word held in m_data is lost; the FIFOs are reset in the same domain.
- Widths: burst_cnt is clog2(BURST_MAX+1) bits and never exceeds BURST_MAX.

Decomposition:
- Shared package holds:
  - state enum {IDLE, BURST};
  - function clog2 used for m_chan and burst_cnt widths.
- One natural sub-module: rr_pick, a combinational round-robin picker.
  - Inputs: req[NUM_CH], last[clog2(NUM_CH)].
  - Outputs: gnt one-hot, gnt_idx, any.
  - Reusable by the write-side scheduler.

Test Plan:
- Reset, all channels empty, m_ready=1:
  - rinc_o=0, m_valid=0, grant_o=0, busy=0 indefinitely;
  - assert rst_n low mid-burst and expect all outputs at reset values immediately.
- Channel 2 holds 10 words, BURST_MAX=4, m_ready=1:
  - pops in groups 4,4,2 with one-cycle IDLE bubbles;
  - m_chan=2 throughout, and data order matches write order.
- Channels 0, 1 and 3 each hold 8 words:
  - grant order is 0,1,3,0,1,3, each burst exactly 4 words;
  - channel 2 is never granted.
- Channel 1 active, m_ready held low for 5 cycles after the first word:
  - m_data stays stable, rinc_o=0 and burst_cnt is held;
  - after release, pops resume and the total count is correct.
- ch_en[0] dropped during a burst on channel 0 with 3 words left:
  - pops stop that cycle and the FIFO retains 3 words;
  - the next grant goes to another eligible channel.
- Random occupancy and m_ready over 10k cycles, checked with a scoreboard:
  - per-channel in-order delivery, no pop while empty, rinc_o one-hot-or-zero;
  - starvation bound of (NUM_CH-1)*(BURST_MAX+1) cycles per eligible channel under m_ready=1.
